ld_nb_unit: RTL and testbench

- Non-blocking, parametrised load unit serving LD and LDR from the reservation stations.
- Holds up to DEPTH loads in flight in a load buffer, backed by one fully-associative L1D of NUM_LINES words.
- A miss issues one request to the long-latency data port; requests to the same address can be merged.
- Results return to the common result path one per cycle, possibly out of order; rs_num_out identifies each result.

---
 rtl/ld_pkg.sv | 28 ++
 rtl/ld_fa_cache.sv | 71 +++++++
 rtl/ld_nb_unit.sv | 193 +++++++++++++++++++
 tb/tb_ld_nb_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ld_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ld_pkg
// Description : Opcodes, load-buffer entry states and effective-address helper
// Revision    : 1.0
// ============================================================================
package ld_pkg;

    localparam logic [3:0] OP_LD  = 4'd4;
    localparam logic [3:0] OP_LDR = 4'd5;

    typedef enum logic [2:0] {
        ST_FREE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } ent_state_t;

    // Computed at 32 bits; callers truncate to their address width, giving wrap.
    function automatic logic [31:0] eff_addr(input logic [3:0]  op,
                                             input logic [31:0] base,
                                             input logic [31:0] offset);
        return (op == OP_LDR) ? (base + offset) : base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ld_fa_cache.sv
`default_nettype none
// ============================================================================
// Module      : ld_fa_cache
// Description : Fully-associative one-word-per-line cache, FIFO replacement
// Revision    : 1.0
// ============================================================================
module ld_fa_cache #(
    parameter int NUM_LINES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data
);

    localparam int PTR_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    logic              r_valid [NUM_LINES];
    logic [ADDR_W-1:0] r_tag   [NUM_LINES];
    logic [DATA_W-1:0] r_data  [NUM_LINES];
    logic [PTR_W-1:0]  r_ptr;

    logic              w_res_hit;
    logic [PTR_W-1:0]  w_res_idx;

    always_comb begin
        hit       = 1'b0;
        hit_data  = '0;
        w_res_hit = 1'b0;
        w_res_idx = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (r_valid[i] && (r_tag[i] == lookup_addr)) begin
                hit      = 1'b1;
                hit_data = r_data[i];
            end
            if (r_valid[i] && (r_tag[i] == fill_addr)) begin
                w_res_hit = 1'b1;
                w_res_idx = PTR_W'(i);
            end
        end
    end

    // A refill of a resident address rewrites that line and leaves the FIFO alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                r_valid[i] <= 1'b0;
                r_tag[i]   <= '0;
                r_data[i]  <= '0;
            end
            r_ptr <= '0;
        end else if (fill_en) begin
            if (w_res_hit) begin
                r_data[w_res_idx] <= fill_data;
            end else begin
                r_valid[r_ptr] <= 1'b1;
                r_tag[r_ptr]   <= fill_addr;
                r_data[r_ptr]  <= fill_data;
                r_ptr          <= (r_ptr == PTR_W'(NUM_LINES - 1)) ? '0 : r_ptr + PTR_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ld_nb_unit.sv
`default_nettype none
// ============================================================================
// Module      : ld_nb_unit
// Description : Non-blocking LD/LDR unit: load buffer, miss issue, retire.
//               Define LD_MERGE_EN to merge same-address outstanding misses.
// Revision    : 1.0
// ============================================================================
module ld_nb_unit
    import ld_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int RS_W      = 6,
    parameter int DEPTH     = 4,
    parameter int NUM_LINES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic [RS_W-1:0]   rs_num,
    input  logic [3:0]        op,
    input  logic [ADDR_W-1:0] val0,
    input  logic [ADDR_W-1:0] val1,
    output logic              busy,
    output logic              valid_out,
    output logic [RS_W-1:0]   rs_num_out,
    output logic [3:0]        op_out,
    output logic [DATA_W-1:0] res_out,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr_out,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    ent_state_t        r_state    [DEPTH];
    ent_state_t        w_state_nxt[DEPTH];
    logic [ADDR_W-1:0] r_addr     [DEPTH];
    logic [RS_W-1:0]   r_rs       [DEPTH];
    logic [3:0]        r_op       [DEPTH];
    logic [DATA_W-1:0] r_data     [DEPTH];
    logic [DATA_W-1:0] w_data_nxt [DEPTH];

    logic [DEPTH-1:0]  w_fill_match;
    logic              w_free_any, w_lk_any, w_iss_any, w_ret_any;
    logic [IDX_W-1:0]  w_free_idx, w_lk_idx, w_iss_idx, w_ret_idx;
    logic              w_accept, w_merge, w_hit;
    logic [ADDR_W-1:0] w_new_addr, w_lk_addr;
    logic [DATA_W-1:0] w_hit_data;

    assign w_new_addr = ADDR_W'(eff_addr(op, 32'(val0), 32'(val1)));
    assign w_accept   = valid && w_free_any;
    assign busy       = !w_free_any;
    assign w_lk_addr  = r_addr[w_lk_idx];
    assign mem_re     = w_iss_any;
    assign mem_raddr  = r_addr[w_iss_idx];

    always_comb begin
        w_fill_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fill_match[i] = mem_ready && (r_addr[i] == mem_addr_out);
        end
    end

    // Priority pickers: descending scan leaves the lowest matching index.
    always_comb begin
        w_free_any = 1'b0;  w_free_idx = '0;
        w_lk_any   = 1'b0;  w_lk_idx   = '0;
        w_iss_any  = 1'b0;  w_iss_idx  = '0;
        w_ret_any  = 1'b0;  w_ret_idx  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_any = 1'b1;  w_free_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_LOOKUP) begin
                w_lk_any = 1'b1;  w_lk_idx = IDX_W'(i);
            end
            if ((r_state[i] == ST_ISSUE) && !w_fill_match[i]) begin
                w_iss_any = 1'b1;  w_iss_idx = IDX_W'(i);
            end
            if (r_state[i] == ST_DONE) begin
                w_ret_any = 1'b1;  w_ret_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_merge = 1'b0;
`ifdef LD_MERGE_EN
        for (int j = 0; j < DEPTH; j++) begin
            if (w_lk_any && ((r_state[j] == ST_ISSUE) || (r_state[j] == ST_WAIT)) &&
                (r_addr[j] == w_lk_addr)) begin
                w_merge = 1'b1;
            end
        end
`endif
    end

    ld_fa_cache #(
        .NUM_LINES (NUM_LINES),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_l1d (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (w_lk_addr),
        .hit         (w_hit),
        .hit_data    (w_hit_data),
        .fill_en     (mem_ready),
        .fill_addr   (mem_addr_out),
        .fill_data   (mem_data_out)
    );

    // At most one entry is in LOOKUP per cycle, so the single cache port suffices.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nxt[i] = r_state[i];
            w_data_nxt[i]  = r_data[i];
            case (r_state[i])
                ST_FREE: begin
                    if (w_accept && (w_free_idx == IDX_W'(i))) w_state_nxt[i] = ST_LOOKUP;
                end
                ST_LOOKUP: begin
                    if (w_fill_match[i]) begin
                        w_state_nxt[i] = ST_DONE;
                        w_data_nxt[i]  = mem_data_out;
                    end else if (w_hit) begin
                        w_state_nxt[i] = ST_DONE;
                        w_data_nxt[i]  = w_hit_data;
                    end else if (w_merge) begin
                        w_state_nxt[i] = ST_WAIT;
                    end else begin
                        w_state_nxt[i] = ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (w_fill_match[i]) begin
                        w_state_nxt[i] = ST_DONE;
                        w_data_nxt[i]  = mem_data_out;
                    end else if (w_iss_any && (w_iss_idx == IDX_W'(i))) begin
                        w_state_nxt[i] = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_fill_match[i]) begin
                        w_state_nxt[i] = ST_DONE;
                        w_data_nxt[i]  = mem_data_out;
                    end
                end
                ST_DONE: begin
                    if (w_ret_any && (w_ret_idx == IDX_W'(i))) w_state_nxt[i] = ST_FREE;
                end
                default: w_state_nxt[i] = ST_FREE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_addr[i]  <= '0;
                r_rs[i]    <= '0;
                r_op[i]    <= '0;
                r_data[i]  <= '0;
            end
            valid_out  <= 1'b0;
            rs_num_out <= '0;
            op_out     <= '0;
            res_out    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_data[i]  <= w_data_nxt[i];
                if (w_accept && (w_free_idx == IDX_W'(i))) begin
                    r_addr[i] <= w_new_addr;
                    r_rs[i]   <= rs_num;
                    r_op[i]   <= op;
                end
            end
            valid_out <= w_ret_any;
            if (w_ret_any) begin
                rs_num_out <= r_rs[w_ret_idx];
                op_out     <= r_op[w_ret_idx];
                res_out    <= r_data[w_ret_idx];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ld_nb_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ld_nb_unit
// Description : Scoreboard bench for ld_nb_unit (directed vectors)
// Revision    : 1.0
// ============================================================================
module tb_ld_nb_unit;

    localparam logic [3:0] c_LD  = 4'd4;
    localparam logic [3:0] c_LDR = 4'd5;

    typedef struct {
        logic [5:0]  rs;
        logic [3:0]  op;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [5:0]  rs_num;
    logic [3:0]  op;
    logic [15:0] val0, val1;
    logic        busy, valid_out, mem_re;
    logic [5:0]  rs_num_out;
    logic [3:0]  op_out;
    logic [15:0] res_out, mem_raddr;
    logic        mem_ready;
    logic [15:0] mem_addr_out, mem_data_out;

    exp_t        exp_q[$];
    logic [15:0] req_q[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          acc;

    ld_nb_unit #(
        .ADDR_W(16), .DATA_W(16), .RS_W(6), .DEPTH(4), .NUM_LINES(4)
    ) dut (
        .clk(clk), .rst(rst), .valid(valid), .rs_num(rs_num), .op(op),
        .val0(val0), .val1(val1), .busy(busy), .valid_out(valid_out),
        .rs_num_out(rs_num_out), .op_out(op_out), .res_out(res_out),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_ready(mem_ready),
        .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a result or request.
    always @(negedge clk) begin : mon
        exp_t e;
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL result_unexpected actual rs=%0d data=%h required none", rs_num_out, res_out);
            end else begin
                e = exp_q.pop_front();
                check("res_rs", 32'(rs_num_out), 32'(e.rs));
                check("res_op", 32'(op_out), 32'(e.op));
                check("res_data", 32'(res_out), 32'(e.data));
                if (e.cyc >= 0) check("res_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (mem_re) begin
            if (req_q.size() == 0) begin
                n_vec++; n_fail++;
                $display("FAIL memreq_unexpected actual addr=%h required none", mem_raddr);
            end else begin
                check("mem_raddr", 32'(mem_raddr), 32'(req_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] rs, input logic [3:0] o,
                        input logic [15:0] a, input logic [15:0] b, output int acc_cyc);
        valid = 1'b1; rs_num = rs; op = o; val0 = a; val1 = b;
        tick(1);
        acc_cyc = cyc;
        valid = 1'b0;
    endtask

    task automatic fill(input logic [15:0] a, input logic [15:0] d);
        mem_ready = 1'b1; mem_addr_out = a; mem_data_out = d;
        tick(1);
        mem_ready = 1'b0;
    endtask

    task automatic expect_res(input logic [5:0] rs, input logic [3:0] o,
                              input logic [15:0] d, input int c);
        exp_q.push_back('{rs: rs, op: o, data: d, cyc: c});
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || req_q.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
        n_vec++;
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s pending results=%0d requests=%0d required 0", name, exp_q.size(), req_q.size());
            exp_q.delete();
            req_q.delete();
        end
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; valid = 1'b0; rs_num = '0; op = '0; val0 = '0; val1 = '0;
        mem_ready = 1'b0; mem_addr_out = '0; mem_data_out = '0;
        #1;
        check("reset_valid_out", 32'(valid_out), 0);
        check("reset_mem_re", 32'(mem_re), 0);
        check("reset_busy", 32'(busy), 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Cold miss, then hit on the same address with exact two-cycle latency.
        req_q.push_back(16'h0010);
        load(6'd1, c_LD, 16'h0010, 16'h0000, acc);
        tick(100);
        expect_res(6'd1, c_LD, 16'hBEEF, -1);
        fill(16'h0010, 16'hBEEF);
        drain("cold_miss", 20);
        load(6'd2, c_LD, 16'h0010, 16'h0000, acc);
        expect_res(6'd2, c_LD, 16'hBEEF, acc + 2);
        drain("hit", 10);

        // LDR with address wrap.
        req_q.push_back(16'h0001);
        load(6'd3, c_LDR, 16'hFFFF, 16'h0002, acc);
        tick(5);
        expect_res(6'd3, c_LDR, 16'h1234, -1);
        fill(16'h0001, 16'h1234);
        drain("ldr_wrap", 10);

        // Three same-address misses on consecutive cycles.
        req_q.push_back(16'h0020);
`ifndef LD_MERGE_EN
        req_q.push_back(16'h0020);
        req_q.push_back(16'h0020);
`endif
        load(6'd4, c_LD, 16'h0020, 16'h0000, acc);
        load(6'd5, c_LD, 16'h0020, 16'h0000, acc);
        load(6'd6, c_LD, 16'h0020, 16'h0000, acc);
        tick(10);
        fill(16'h0020, 16'hCAFE);
        expect_res(6'd4, c_LD, 16'hCAFE, cyc + 1);
        expect_res(6'd5, c_LD, 16'hCAFE, cyc + 2);
        expect_res(6'd6, c_LD, 16'hCAFE, cyc + 3);
        drain("merge", 10);

        // Buffer full, release by one retire, then a fifth (hit) load.
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(16'h0040 + 16'(i));
            load(6'd8 + 6'(i), c_LD, 16'h0040 + 16'(i), 16'h0000, acc);
        end
        check("full_busy", 32'(busy), 1);
        tick(5);
        expect_res(6'd9, c_LD, 16'h4141, -1);
        fill(16'h0041, 16'h4141);
        check("busy_before_retire", 32'(busy), 1);
        tick(1);
        check("busy_after_retire", 32'(busy), 0);
        load(6'd12, c_LD, 16'h0010, 16'h0000, acc);
        expect_res(6'd12, c_LD, 16'hBEEF, acc + 2);
        tick(3);
        expect_res(6'd8, c_LD, 16'h4040, -1);
        fill(16'h0040, 16'h4040);
        tick(2);
        expect_res(6'd10, c_LD, 16'h4242, -1);
        fill(16'h0042, 16'h4242);
        tick(2);
        expect_res(6'd11, c_LD, 16'h4343, -1);
        fill(16'h0043, 16'h4343);
        drain("full", 10);

        // Out of order: later hit overtakes earlier miss.
        req_q.push_back(16'h0030);
        load(6'd13, c_LD, 16'h0030, 16'h0000, acc);
        load(6'd14, c_LD, 16'h0042, 16'h0000, acc);
        expect_res(6'd14, c_LD, 16'h4242, acc + 2);
        tick(5);
        expect_res(6'd13, c_LD, 16'h3030, -1);
        fill(16'h0030, 16'h3030);
        drain("out_of_order", 10);

        // Reset while loads are waiting; late fills still land in the L1D.
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(16'h0050 + 16'(i));
            load(6'd15 + 6'(i), c_LD, 16'h0050 + 16'(i), 16'h0000, acc);
        end
        check("pre_reset_busy", 32'(busy), 1);
        tick(3);
        rst = 1'b1;
        #1;
        check("midreset_valid_out", 32'(valid_out), 0);
        check("midreset_busy", 32'(busy), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
        fill(16'h0050, 16'h5050);
        tick(2);
        fill(16'h0051, 16'h5151);
        tick(5);
        load(6'd19, c_LD, 16'h0050, 16'h0000, acc);
        expect_res(6'd19, c_LD, 16'h5050, acc + 2);
        drain("post_reset_hit", 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
